// File: rtl/dcsf_pkg.sv
// Shared types and width helpers for the DCSformer Gram/threshold/weight engine.
// DCSF_SIGNED_EN switches the element arithmetic to two's complement.
package dcsf_pkg;

    typedef enum logic [2:0] {IDLE, LOAD, GRAM, THRESH, WAIT_W, OUT} state_t;

    localparam int DEF_DW       = 8;
    localparam int DEF_N_ROW    = 8;
    localparam int DEF_N_COL    = 16;
    localparam int DEF_NUM_WVEC = 1;
    localparam int DEF_OW       = 32;

`ifdef DCSF_SIGNED_EN
    localparam bit ELEM_SIGNED = 1'b1;
`else
    localparam bit ELEM_SIGNED = 1'b0;
`endif

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    // Gram element width; the signed build needs one extra bit for the sign.
    function automatic int hw_of(input int dw, input int n_col);
        return 2 * dw + $clog2(n_col) + (ELEM_SIGNED ? 1 : 0);
    endfunction

    localparam int DEF_HW = hw_of(DEF_DW, DEF_N_COL);

`ifdef DCSF_SIGNED_EN
    typedef logic signed [DEF_HW-1:0] elem_t;
`else
    typedef logic [DEF_HW-1:0] elem_t;
`endif

endpackage

// File: rtl/dcsf_gram_engine_if.sv
// Activation, weight and result streams of the Gram engine, each valid/ready.
interface dcsf_gram_engine_if #(
    parameter int DW = 8,
    parameter int OW = 32
);
    logic          i_valid;
    logic          i_ready;
    logic [DW-1:0] i_data;
    logic          w_valid;
    logic          w_ready;
    logic [DW-1:0] w_data;
    logic          o_valid;
    logic          o_ready;
    logic [OW-1:0] o_data;
    logic          o_last;

    modport master (
        output i_valid, i_data, w_valid, w_data, o_ready,
        input  i_ready, w_ready, o_valid, o_data, o_last
    );

    modport slave (
        input  i_valid, i_data, w_valid, w_data, o_ready,
        output i_ready, w_ready, o_valid, o_data, o_last
    );
endinterface

// File: rtl/dcsf_row_thresh.sv
// One H row: floor row average, then zero every element strictly below it.
// Purely combinational; no handshake.
module dcsf_row_thresh
    import dcsf_pkg::*;
#(
    parameter int HW    = 20,
    parameter int N_ROW = 8
) (
    input  logic [N_ROW-1:0][HW-1:0] row_in,
    output logic [N_ROW-1:0][HW-1:0] row_out
);
    localparam int LR = $clog2(N_ROW);
    localparam int SW = HW + LR;
    // Flipping the MSB turns a two's-complement compare into an unsigned one.
    localparam logic [HW-1:0] FLIP = {ELEM_SIGNED, {(HW-1){1'b0}}};

    logic [SW-1:0] sum;
    logic [HW-1:0] avg;

    always_comb begin
        sum = '0;
        for (int c = 0; c < N_ROW; c++) begin
            sum = sum + {{LR{ELEM_SIGNED & row_in[c][HW-1]}}, row_in[c]};
        end
        // Dropping the low LR bits is a floor divide for both signednesses.
        avg = sum[SW-1:LR];
        for (int c = 0; c < N_ROW; c++) begin
            row_out[c] = ((row_in[c] ^ FLIP) < (avg ^ FLIP)) ? '0 : row_in[c];
        end
    end
endmodule

// File: rtl/dcsf_gram_engine.sv
// Loads X, builds H = X*X^T over N_COL cycles, thresholds rows, then applies
// NUM_WVEC weight vectors; results stall under o_ready. DCSF_SIGNED_EN = signed.
module dcsf_gram_engine
    import dcsf_pkg::*;
#(
    parameter int DW       = DEF_DW,
    parameter int N_ROW    = DEF_N_ROW,
    parameter int N_COL    = DEF_N_COL,
    parameter int NUM_WVEC = DEF_NUM_WVEC,
    parameter int OW       = DEF_OW
) (
    input  logic               clk,
    input  logic               rst_n,
    dcsf_gram_engine_if.slave  bus,
    output logic               busy
);
    localparam int HW = hw_of(DW, N_COL);
    localparam int RW = cnt_w(N_ROW);
    localparam int CW = cnt_w(N_COL);
    localparam int VW = cnt_w(NUM_WVEC);

    state_t state;

    logic [N_ROW-1:0][N_COL-1:0][DW-1:0] x_mem;
    logic [N_ROW-1:0][N_ROW-1:0][HW-1:0] h_mat;
    logic [N_ROW-1:0][N_ROW-1:0][HW-1:0] h_thr;
    logic [N_ROW-1:0][N_ROW-1:0][HW-1:0] gram_nxt;
    logic [N_ROW-1:0][OW-1:0]            acc;

    logic [RW-1:0] row_cnt;
    logic [RW-1:0] wj_cnt;
    logic [RW-1:0] idx;
    logic [CW-1:0] col_cnt;
    logic [CW-1:0] k_cnt;
    logic [VW-1:0] vec_cnt;

    // Extensions keep the modular products correct in either signedness.
    function automatic logic [HW-1:0] d2h(input logic [DW-1:0] v);
        logic [HW-1:0] r;
        r = HW'(v);
        if (ELEM_SIGNED && v[DW-1]) r = r | ~(HW'({DW{1'b1}}));
        return r;
    endfunction

    function automatic logic [OW-1:0] h2o(input logic [HW-1:0] v);
        logic [OW-1:0] r;
        r = OW'(v);
        if (ELEM_SIGNED && v[HW-1]) r = r | ~(OW'({HW{1'b1}}));
        return r;
    endfunction

    // Upper triangle accumulates; each new sum also lands in its mirror slot.
    always_comb begin
        logic [HW-1:0] s;
        s        = '0;
        gram_nxt = h_mat;
        for (int r = 0; r < N_ROW; r++) begin
            for (int c = r; c < N_ROW; c++) begin
                s = h_mat[r][c] + d2h(x_mem[r][k_cnt]) * d2h(x_mem[c][k_cnt]);
                gram_nxt[r][c] = s;
                gram_nxt[c][r] = s;
            end
        end
    end

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        dcsf_row_thresh #(
            .HW    (HW),
            .N_ROW (N_ROW)
        ) u_thr (
            .row_in  (h_mat[r]),
            .row_out (h_thr[r])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            x_mem       <= '0;
            h_mat       <= '0;
            acc         <= '0;
            row_cnt     <= '0;
            col_cnt     <= '0;
            k_cnt       <= '0;
            wj_cnt      <= '0;
            idx         <= '0;
            vec_cnt     <= '0;
            bus.i_ready <= 1'b0;
            bus.w_ready <= 1'b0;
            bus.o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, LOAD: begin
                    bus.i_ready <= 1'b1;
                    if (bus.i_valid && bus.i_ready) begin
                        x_mem[row_cnt][col_cnt] <= bus.i_data;
                        state                   <= LOAD;
                        if (col_cnt == CW'(N_COL - 1)) begin
                            col_cnt <= '0;
                            if (row_cnt == RW'(N_ROW - 1)) begin
                                row_cnt     <= '0;
                                k_cnt       <= '0;
                                bus.i_ready <= 1'b0;
                                state       <= GRAM;
                            end else begin
                                row_cnt <= row_cnt + RW'(1);
                            end
                        end else begin
                            col_cnt <= col_cnt + CW'(1);
                        end
                    end
                end
                GRAM: begin
                    h_mat <= gram_nxt;
                    if (k_cnt == CW'(N_COL - 1)) begin
                        k_cnt <= '0;
                        state <= THRESH;
                    end else begin
                        k_cnt <= k_cnt + CW'(1);
                    end
                end
                THRESH: begin
                    h_mat       <= h_thr;
                    acc         <= '0;
                    wj_cnt      <= '0;
                    bus.w_ready <= 1'b1;
                    state       <= WAIT_W;
                end
                WAIT_W: begin
                    if (bus.w_valid && bus.w_ready) begin
                        for (int r = 0; r < N_ROW; r++) begin
                            acc[r] <= acc[r] + h2o(h_mat[r][wj_cnt]) * h2o(d2h(bus.w_data));
                        end
                        if (wj_cnt == RW'(N_ROW - 1)) begin
                            wj_cnt      <= '0;
                            idx         <= '0;
                            bus.w_ready <= 1'b0;
                            bus.o_valid <= 1'b1;
                            state       <= OUT;
                        end else begin
                            wj_cnt <= wj_cnt + RW'(1);
                        end
                    end
                end
                OUT: begin
                    if (bus.o_valid && bus.o_ready) begin
                        if (idx == RW'(N_ROW - 1)) begin
                            idx         <= '0;
                            bus.o_valid <= 1'b0;
                            if (vec_cnt == VW'(NUM_WVEC - 1)) begin
                                vec_cnt     <= '0;
                                h_mat       <= '0;
                                bus.i_ready <= 1'b1;
                                state       <= IDLE;
                            end else begin
                                // H is reused; only the accumulators restart.
                                vec_cnt     <= vec_cnt + VW'(1);
                                acc         <= '0;
                                bus.w_ready <= 1'b1;
                                state       <= WAIT_W;
                            end
                        end else begin
                            idx <= idx + RW'(1);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.o_data = bus.o_valid ? acc[idx] : '0;
    assign bus.o_last = bus.o_valid && (idx == RW'(N_ROW - 1));
    assign busy       = (state != IDLE);
endmodule
